alarm_game_ctrl: RTL and testbench

Second-generation alarm service: arms on an enable switch, rings once per time match, and requires the user to win a switch-matching minigame of N_ROUNDS rounds to silence the alarm. Compared with the first-generation service, it adds parametrised switch count, round count and round timeout. It also adds single-fire per match, mistake and timeout penalties, and guaranteed target change between rounds. It sits between the clock/alarm time registers and the LED/7-segment display logic.

---
 rtl/alarm_game_pkg.sv | 20 ++
 rtl/alarm_game_lfsr.sv | 24 ++
 rtl/alarm_game_ctrl.sv | 159 +++++++++++++++
 tb/tb_alarm_game_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_game_pkg.sv
// Shared types and constants for the alarm minigame controller.
package alarm_game_pkg;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_GAME    = 3'd3
  } state_t;

  typedef enum logic {
    PH_CLEAR = 1'b0,
    PH_MATCH = 1'b1
  } phase_t;

  localparam int LFSR_W = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 as feedback taps on bits 7,5,4,3
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/alarm_game_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick game targets.
module alarm_game_lfsr
  import alarm_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = ^(r_q & LFSR_TAPS);

  always_ff @(posedge clk) begin
    if (reset) r_q <= SEED;
    else       r_q <= {r_q[LFSR_W-2:0], w_fb};
  end

  assign q = r_q;

endmodule

// File: rtl/alarm_game_ctrl.sv
// Alarm service: arm, ring once per time match, silence by winning
// a switch-matching minigame within a per-round timeout.
module alarm_game_ctrl
  import alarm_game_pkg::*;
#(
  parameter int unsigned       TIME_W   = 16,
  parameter int unsigned       N_SW     = 10,
  parameter int unsigned       N_ROUNDS = 3,
  parameter int unsigned       ROUND_TO = 500_000_000,
  parameter logic [LFSR_W-1:0] SEED     = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [TIME_W-1:0] current_time,
  input  logic [TIME_W-1:0] alarm_time,
  input  logic              push_m,
  input  logic [N_SW-1:0]   switches,
  output logic [2:0]        alarm_state,
  output logic              ringing,
  output logic [N_SW-1:0]   target_led,
  output logic [3:0]        round_cnt,
  output logic              done
);

  localparam int unsigned TW = (ROUND_TO > 1) ? $clog2(ROUND_TO) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(ROUND_TO - 1);
  localparam logic [3:0]    LAST_RND = 4'(N_ROUNDS - 1);
  localparam logic [3:0]    TOP_IDX  = 4'(N_SW - 1);

  state_t            r_state, n_state;
  phase_t            r_phase, n_phase;
  logic [3:0]        r_round, n_round;
  logic [N_SW-1:0]   r_tgt, n_tgt;
  logic [TW-1:0]     r_timer, n_timer;
  logic              r_done, n_done;
  logic              r_fired, n_fired;
  logic              r_push_prev;

  logic [LFSR_W-1:0] w_lfsr;
  logic [3:0]        w_idx0, w_idx1;
  logic [N_SW-1:0]   w_one0, w_new_tgt;
  logic              w_tmatch, w_push, w_timeout, w_sw_zero, w_last;

  alarm_game_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (w_lfsr)
  );

  // Step to the next switch if the draw would repeat the current target
  assign w_idx0    = 4'(32'(w_lfsr) % N_SW);
  assign w_idx1    = (w_idx0 == TOP_IDX) ? 4'd0 : w_idx0 + 4'd1;
  assign w_one0    = N_SW'(1) << w_idx0;
  assign w_new_tgt = (w_one0 == r_tgt) ? (N_SW'(1) << w_idx1) : w_one0;

  assign w_tmatch  = (current_time == alarm_time);
  assign w_push    = push_m & ~r_push_prev;
  assign w_timeout = (r_timer == TO_LAST);
  assign w_sw_zero = (switches == '0);
  assign w_last    = (r_round == LAST_RND);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_OFF;
      r_phase     <= PH_CLEAR;
      r_round     <= '0;
      r_tgt       <= '0;
      r_timer     <= '0;
      r_done      <= 1'b0;
      r_fired     <= 1'b0;
      r_push_prev <= 1'b0;
    end else begin
      r_state     <= n_state;
      r_phase     <= n_phase;
      r_round     <= n_round;
      r_tgt       <= n_tgt;
      r_timer     <= n_timer;
      r_done      <= n_done;
      r_fired     <= n_fired;
      r_push_prev <= push_m;
    end
  end

  always_comb begin
    n_state = r_state;
    n_phase = r_phase;
    n_round = r_round;
    n_tgt   = r_tgt;
    n_timer = r_timer;
    n_done  = 1'b0;
    n_fired = w_tmatch ? r_fired : 1'b0;
    if (!enable) begin
      n_state = ST_OFF;
      n_phase = PH_CLEAR;
      n_round = '0;
      n_tgt   = '0;
      n_timer = '0;
    end else begin
      unique case (r_state)
        ST_OFF: n_state = ST_ARMED;
        ST_ARMED: begin
          if (w_tmatch && !r_fired) begin
            n_state = ST_RINGING;
            n_fired = 1'b1;
          end
        end
        ST_RINGING: begin
          if (w_push) begin
            n_state = ST_GAME;
            n_phase = PH_CLEAR;
            n_round = '0;
            n_tgt   = w_new_tgt;
            n_timer = '0;
          end
        end
        ST_GAME: begin
          if (w_timeout) begin
            n_state = ST_RINGING;
            n_phase = PH_CLEAR;
            n_round = '0;
            n_tgt   = '0;
            n_timer = '0;
          end else begin
            n_timer = r_timer + TW'(1);
            if (r_phase == PH_CLEAR) begin
              if (w_sw_zero) n_phase = PH_MATCH;
            end else if (switches == r_tgt) begin
              n_phase = PH_CLEAR;
              n_timer = '0;
              if (w_last) begin
                n_done  = 1'b1;
                n_state = ST_ARMED;
                n_round = '0;
                n_tgt   = '0;
              end else begin
                n_round = r_round + 4'd1;
                n_tgt   = w_new_tgt;
              end
            end else if (!w_sw_zero) begin
              n_phase = PH_CLEAR;
              n_round = '0;
              n_tgt   = w_new_tgt;
              n_timer = '0;
            end
          end
        end
        default: n_state = ST_OFF;
      endcase
    end
  end

  assign alarm_state = r_state;
  assign ringing     = (r_state == ST_RINGING);
  assign target_led  = r_tgt;
  assign round_cnt   = r_round;
  assign done        = r_done;

endmodule

// File: tb/tb_alarm_game_ctrl.sv
// Randomised and directed bench for alarm_game_ctrl against a
// cycle-level behavioural model of the alarm/game rules.
module tb_alarm_game_ctrl;

  localparam int NSW = 10;
  localparam int NR  = 3;
  localparam int TO  = 20;
  localparam int SD  = 8'hA5;
  localparam int OFF = 0, ARMED = 1, RING = 2, GAME = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [15:0]     current_time = 16'h0000;
  logic [15:0]     alarm_time = 16'h0730;
  logic            push_m = 1'b0;
  logic [NSW-1:0]  switches = '0;
  logic [2:0]      alarm_state;
  logic            ringing;
  logic [NSW-1:0]  target_led;
  logic [3:0]      round_cnt;
  logic            done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // model state
  int             m_st = OFF, m_ph = 0, m_round = 0, m_timer = 0;
  int             m_lfsr = SD;
  bit             m_fired = 0, m_prev = 0, m_done = 0;
  logic [NSW-1:0] m_tgt = '0;

  logic [18:0] obs;
  assign obs = {alarm_state, ringing, target_led, round_cnt, done};

  alarm_game_ctrl #(
    .TIME_W(16), .N_SW(NSW), .N_ROUNDS(NR),
    .ROUND_TO(TO), .SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .current_time(current_time), .alarm_time(alarm_time),
    .push_m(push_m), .switches(switches),
    .alarm_state(alarm_state), .ringing(ringing),
    .target_led(target_led), .round_cnt(round_cnt), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [NSW-1:0] pick(int l, logic [NSW-1:0] cur);
    int idx;
    idx = l % NSW;
    if ((NSW'(1) << idx) == cur) idx = (idx + 1) % NSW;
    return NSW'(1) << idx;
  endfunction

  function automatic logic [18:0] exp_vec();
    return {3'(m_st), m_st == RING, m_tgt, 4'(m_round), m_done};
  endfunction

  task automatic model_step();
    int s, ph, rc, tm, fb;
    logic [NSW-1:0] tg;
    bit fd, dn, match, edg;
    s = m_st; ph = m_ph; rc = m_round; tm = m_timer; tg = m_tgt;
    fd = m_fired; dn = 0;
    match = (current_time == alarm_time);
    edg = push_m && !m_prev;
    if (!match) fd = 0;
    if (reset) begin
      s = OFF; ph = 0; rc = 0; tg = '0; tm = 0; fd = 0;
    end else if (!enable) begin
      s = OFF; ph = 0; rc = 0; tg = '0; tm = 0;
    end else if (m_st == OFF) begin
      s = ARMED;
    end else if (m_st == ARMED) begin
      if (match && !m_fired) begin s = RING; fd = 1; end
    end else if (m_st == RING) begin
      if (edg) begin
        s = GAME; tg = pick(m_lfsr, m_tgt); rc = 0; tm = 0; ph = 0;
      end
    end else if (m_timer == TO - 1) begin
      s = RING; rc = 0; tg = '0; tm = 0; ph = 0;
    end else begin
      tm = m_timer + 1;
      if (m_ph == 0) begin
        if (switches == 0) ph = 1;
      end else if (switches == m_tgt) begin
        tm = 0; ph = 0;
        if (m_round + 1 == NR) begin
          dn = 1; s = ARMED; rc = 0; tg = '0;
        end else begin
          rc = m_round + 1; tg = pick(m_lfsr, m_tgt);
        end
      end else if (switches != 0) begin
        rc = 0; tg = pick(m_lfsr, m_tgt); tm = 0; ph = 0;
      end
    end
    m_st = s; m_ph = ph; m_round = rc; m_timer = tm; m_tgt = tg;
    m_fired = fd; m_done = dn;
    m_prev = reset ? 1'b0 : push_m;
    fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
    m_lfsr = reset ? SD : (((m_lfsr << 1) & 255) | fb);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic go_ring();
    current_time = 16'h0729;
    tick();
    tick();
    current_time = 16'h0730;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; enable = 0;
    tick();
    tick();
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs);
    end
    reset = 0;
  endtask

  task automatic test_ring();
    enable = 1;
    alarm_time = 16'h0730;
    current_time = 16'h0729;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL arm cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    current_time = 16'h0730;
    tick();
    total++;
    if (alarm_state !== 3'd2 || ringing !== 1'b1) begin
      bad++;
      $display("FAIL ring_on_match got=%0d,%0b exp=2,1", alarm_state, ringing);
    end
  endtask

  task automatic test_game_win();
    logic [NSW-1:0] prev;
    switches = '0;
    push_m = 1;
    tick();
    push_m = 0;
    total++;
    if (alarm_state !== 3'd3 || target_led === '0) begin
      bad++;
      $display("FAIL game_entry got=%0d tgt=%h exp=3 nonzero", alarm_state, target_led);
    end
    for (int r = 0; r < NR; r++) begin
      switches = '0;
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL win_clear cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      prev = m_tgt;
      switches = m_tgt;
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL win_match cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
      if (r < NR - 1) begin
        total++;
        if (round_cnt !== 4'(r + 1) || target_led === prev || target_led === '0) begin
          bad++;
          $display("FAIL round_adv got=%0d tgt=%h exp=%0d new!=%h", round_cnt, target_led, r + 1, prev);
        end
      end
    end
    total++;
    if (done !== 1'b1 || alarm_state !== 3'd1 || target_led !== '0) begin
      bad++;
      $display("FAIL win_done got=%b,%0d exp=1,1", done, alarm_state);
    end
    switches = '0;
    tick();
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_no_rering();
    for (int i = 0; i < 100; i++) begin
      tick();
      total++;
      if (obs !== exp_vec() || ringing !== 1'b0) begin
        bad++;
        $display("FAIL no_rering cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    current_time = 16'h0731;
    tick();
    current_time = 16'h0730;
    tick();
    total++;
    if (alarm_state !== 3'd2) begin
      bad++;
      $display("FAIL rering got=%0d exp=2", alarm_state);
    end
  endtask

  task automatic test_mistake();
    logic [NSW-1:0] wrong, old;
    switches = '0;
    push_m = 1;
    tick();
    push_m = 0;
    for (int r = 0; r < 2; r++) begin
      switches = '0;
      tick();
      switches = m_tgt;
      tick();
    end
    switches = '0;
    tick();
    total++;
    if (round_cnt !== 4'd2 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL pre_mistake got=%h exp=%h", obs, exp_vec());
    end
    old = m_tgt;
    do wrong = NSW'($urandom_range(1, 1023)); while (wrong == old);
    switches = wrong;
    tick();
    total++;
    if (round_cnt !== 4'd0 || alarm_state !== 3'd3 || target_led === old ||
        target_led === '0) begin
      bad++;
      $display("FAIL mistake got=%0d,%0d,%h exp=0,3,!=%h", round_cnt, alarm_state, target_led, old);
    end
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL mistake_model got=%h exp=%h", obs, exp_vec());
    end
  endtask

  task automatic test_timeout();
    switches = '0;
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL timeout_wait cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    total++;
    if (alarm_state !== 3'd3) begin
      bad++;
      $display("FAIL timeout_early got=%0d exp=3", alarm_state);
    end
    tick();
    total++;
    if (alarm_state !== 3'd2 || target_led !== '0 || round_cnt !== 4'd0) begin
      bad++;
      $display("FAIL timeout got=%0d,%h exp=2,0", alarm_state, target_led);
    end
  endtask

  task automatic test_enable_drop();
    switches = '0;
    push_m = 1;
    tick();
    push_m = 0;
    tick();
    switches = m_tgt;
    tick();
    total++;
    if (round_cnt !== 4'd1 || alarm_state !== 3'd3) begin
      bad++;
      $display("FAIL pre_drop got=%0d,%0d exp=1,3", round_cnt, alarm_state);
    end
    switches = '0;
    enable = 0;
    tick();
    total++;
    if (alarm_state !== 3'd0 || round_cnt !== 4'd0 || target_led !== '0) begin
      bad++;
      $display("FAIL enable_drop got=%0d,%0d,%h exp=0,0,0", alarm_state, round_cnt, target_led);
    end
    enable = 1;
  endtask

  task automatic test_reset_mid();
    switches = '0;
    go_ring();
    push_m = 1;
    tick();
    push_m = 0;
    tick();
    push_m = 1;
    reset = 1;
    tick();
    reset = 0;
    total++;
    if (obs !== 19'd0) begin
      bad++;
      $display("FAIL reset_mid got=%h exp=0", obs);
    end
    go_ring();
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (alarm_state !== 3'd2 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL held_push got=%0d exp=2", alarm_state);
    end
    push_m = 0;
    tick();
    push_m = 1;
    tick();
    push_m = 0;
    total++;
    if (alarm_state !== 3'd3 || obs !== exp_vec()) begin
      bad++;
      $display("FAIL fresh_push got=%0d exp=3", alarm_state);
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      enable = ($urandom_range(0, 49) != 0);
      current_time = ($urandom_range(0, 7) == 0) ? 16'h0731 : 16'h0730;
      push_m = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 2);
      if (r == 0) switches = '0;
      else if (r == 1) switches = m_tgt;
      else switches = NSW'($urandom);
      tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, exp_vec());
      end
    end
    reset = 0;
    enable = 1;
  endtask

  initial begin
    test_reset();
    test_ring();
    test_game_win();
    test_no_rering();
    test_mistake();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
